// File: rtl/mc_control_v2.sv
// rtl/mc_control_v2.sv - multicycle RV32I control FSM (optional MC_CONTROL_PERF_EN perf counters)
module mc_control_v2 #(
  parameter int MEM_TIMEOUT      = 255,
  parameter int TRAP_ON_MISALIGN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_resp,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       br_en,
  input  logic [1:0] addr_lsb,
  output logic       mem_read,
  output logic       mem_write,
  output logic [3:0] mem_byte_enable,
  output logic       load_pc,
  output logic       load_ir,
  output logic       load_regfile,
  output logic       load_mar,
  output logic       load_mdr,
  output logic       load_data_out,
  output logic [1:0] pcmux_sel,
  output logic       alumux1_sel,
  output logic [2:0] alumux2_sel,
  output logic [3:0] regfilemux_sel,
  output logic       marmux_sel,
  output logic       cmpmux_sel,
  output logic [2:0] aluop,
  output logic [2:0] cmpop,
  output logic       retire,
  output logic       trap,
`ifdef MC_CONTROL_PERF_EN
  output logic       mem_err,
  output logic [31:0] perf_cycle,
  output logic [31:0] perf_instret,
  output logic [31:0] perf_memstall
`else
  output logic       mem_err
`endif
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  // Counter only ever needs to reach MEM_TIMEOUT-1
  localparam int WCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [3:0] {
    FETCH1, FETCH2, FETCH3, DECODE, EXEC, CALC_ADDR, LD1, LD2, ST1, ST2, HALT
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       byte_sel_q;
  logic [WCW-1:0]   wait_cnt_q;
  logic             trap_q, mem_err_q;
  logic             legal, is_load, is_store, misaligned, in_wait, expired;
  logic             unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  // Only bit 5 of funct7 selects sub/sra; the rest is don't-care here
  assign misaligned = ((funct3[1:0] == 2'b10) && (addr_lsb != 2'b00)) ||
                      ((funct3[1:0] == 2'b01) && addr_lsb[0]);
  assign in_wait = (state_q == FETCH2) || (state_q == LD1) || (state_q == ST1);
  // A response on the final allowed cycle still completes normally
  assign expired = (MEM_TIMEOUT > 0) && in_wait && !mem_resp &&
                   (wait_cnt_q == WCW'(MEM_TIMEOUT - 1));
  assign trap    = trap_q;
  assign mem_err = mem_err_q;

  // Decode legality and next-state selection
  always_comb begin
    legal   = 1'b0;
    state_d = state_q;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_REG: legal = 1'b1;
      OP_BR:    legal = (funct3[2:1] != 2'b01);
      OP_LOAD:  legal = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
      OP_STORE: legal = !funct3[2] && (funct3[1:0] != 2'b11);
      default:  legal = 1'b0;
    endcase
    case (state_q)
      FETCH1:    state_d = FETCH2;
      FETCH2:    state_d = mem_resp ? FETCH3 : (expired ? HALT : FETCH2);
      FETCH3:    state_d = DECODE;
      DECODE:    state_d = !legal ? HALT : ((is_load || is_store) ? CALC_ADDR : EXEC);
      EXEC:      state_d = FETCH1;
      CALC_ADDR: state_d = (misaligned && (TRAP_ON_MISALIGN != 0)) ? HALT :
                           (is_load ? LD1 : ST1);
      LD1:       state_d = mem_resp ? LD2 : (expired ? HALT : LD1);
      LD2:       state_d = FETCH1;
      ST1:       state_d = mem_resp ? ST2 : (expired ? HALT : ST1);
      ST2:       state_d = FETCH1;
      default:   state_d = HALT;
    endcase
  end

  // State, byte lane, watchdog, sticky trap and optional perf counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH1;
      byte_sel_q <= 2'b00;
      wait_cnt_q <= '0;
      trap_q     <= 1'b0;
      mem_err_q  <= 1'b0;
`ifdef MC_CONTROL_PERF_EN
      perf_cycle    <= '0;
      perf_instret  <= '0;
      perf_memstall <= '0;
`endif
    end else begin
      state_q   <= state_d;
      mem_err_q <= expired;
      trap_q    <= trap_q || (state_d == HALT);
      if (state_q == CALC_ADDR) byte_sel_q <= addr_lsb;
      if ((state_d != state_q) &&
          ((state_d == FETCH2) || (state_d == LD1) || (state_d == ST1)))
        wait_cnt_q <= '0;
      else if (in_wait && !mem_resp)
        wait_cnt_q <= wait_cnt_q + 1'b1;
`ifdef MC_CONTROL_PERF_EN
      if (state_q != HALT) perf_cycle <= perf_cycle + 32'd1;
      if (retire) perf_instret <= perf_instret + 32'd1;
      if (in_wait && !mem_resp) perf_memstall <= perf_memstall + 32'd1;
`endif
    end
  end

  // Datapath controls decoded from the current state
  always_comb begin
    mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 4'b1111;
    load_pc = 1'b0; load_ir = 1'b0; load_regfile = 1'b0;
    load_mar = 1'b0; load_mdr = 1'b0; load_data_out = 1'b0;
    pcmux_sel = 2'd0; alumux1_sel = 1'b0; alumux2_sel = 3'd0;
    regfilemux_sel = 4'd0; marmux_sel = 1'b0; cmpmux_sel = 1'b0;
    aluop = 3'd0; cmpop = funct3; retire = 1'b0;
    case (state_q)
      FETCH1: load_mar = 1'b1;
      FETCH2: begin mem_read = 1'b1; load_mdr = 1'b1; end
      FETCH3: load_ir = 1'b1;
      EXEC: begin
        load_pc = 1'b1;
        retire  = 1'b1;
        case (opcode)
          OP_LUI: begin load_regfile = 1'b1; regfilemux_sel = 4'd2; end
          OP_AUIPC: begin load_regfile = 1'b1; alumux1_sel = 1'b1; alumux2_sel = 3'd1; end
          OP_JAL: begin
            load_regfile = 1'b1; regfilemux_sel = 4'd4;
            alumux1_sel = 1'b1; alumux2_sel = 3'd4; pcmux_sel = 2'd1;
          end
          OP_JALR: begin load_regfile = 1'b1; regfilemux_sel = 4'd4; pcmux_sel = 2'd2; end
          OP_BR: begin alumux1_sel = 1'b1; alumux2_sel = 3'd2; pcmux_sel = {1'b0, br_en}; end
          default: begin
            load_regfile = 1'b1;
            alumux2_sel  = (opcode == OP_IMM) ? 3'd0 : 3'd5;
            case (funct3)
              3'b010, 3'b011: begin
                // slt/sltu reuse the branch comparator as blt/bltu
                cmpop          = funct3[0] ? 3'b110 : 3'b100;
                regfilemux_sel = 4'd1;
                cmpmux_sel     = (opcode == OP_IMM);
              end
              3'b101:  aluop = funct7[5] ? 3'd2 : 3'd5;
              3'b000:  aluop = ((opcode == OP_REG) && funct7[5]) ? 3'd3 : 3'd0;
              default: aluop = funct3;
            endcase
          end
        endcase
      end
      CALC_ADDR: begin
        alumux2_sel   = is_load ? 3'd0 : 3'd3;
        marmux_sel    = 1'b1;
        load_mar      = 1'b1;
        load_data_out = is_store;
      end
      LD1: begin mem_read = 1'b1; load_mdr = 1'b1; end
      LD2: begin
        load_regfile = 1'b1; load_pc = 1'b1; retire = 1'b1;
        case (funct3)
          3'b000:  regfilemux_sel = 4'd5;
          3'b001:  regfilemux_sel = 4'd7;
          3'b010:  regfilemux_sel = 4'd3;
          3'b100:  regfilemux_sel = 4'd6;
          default: regfilemux_sel = 4'd8;
        endcase
      end
      ST1: begin
        mem_write = 1'b1;
        case (funct3[1:0])
          2'b10:   mem_byte_enable = 4'b1111;
          2'b01:   mem_byte_enable = 4'b0011 << {byte_sel_q[1], 1'b0};
          default: mem_byte_enable = 4'b0001 << byte_sel_q;
        endcase
      end
      ST2: begin load_pc = 1'b1; retire = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control_v2.sv
// tb/tb_mc_control_v2.sv - scoreboard bench for mc_control_v2
module tb_mc_control_v2;
  localparam int MT = 4;

  logic clk = 1'b0, rst = 1'b1, mem_resp = 1'b0, br_en = 1'b0;
  logic [6:0] opcode = '0, funct7 = '0;
  logic [2:0] funct3 = '0;
  logic [1:0] addr_lsb = '0;
  logic mem_read, mem_write, load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
  logic [3:0] mem_byte_enable, regfilemux_sel;
  logic [1:0] pcmux_sel;
  logic alumux1_sel, marmux_sel, cmpmux_sel, retire, trap, mem_err;
  logic [2:0] alumux2_sel, aluop, cmpop;
`ifdef MC_CONTROL_PERF_EN
  logic [31:0] perf_cycle, perf_instret, perf_memstall;
`endif

  mc_control_v2 #(.MEM_TIMEOUT(MT), .TRAP_ON_MISALIGN(1)) dut (
    .clk(clk), .rst(rst), .mem_resp(mem_resp), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .br_en(br_en), .addr_lsb(addr_lsb), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable), .load_pc(load_pc),
    .load_ir(load_ir), .load_regfile(load_regfile), .load_mar(load_mar),
    .load_mdr(load_mdr), .load_data_out(load_data_out), .pcmux_sel(pcmux_sel),
    .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel),
    .regfilemux_sel(regfilemux_sel), .marmux_sel(marmux_sel), .cmpmux_sel(cmpmux_sel),
    .aluop(aluop), .cmpop(cmpop), .retire(retire), .trap(trap),
`ifdef MC_CONTROL_PERF_EN
    .perf_cycle(perf_cycle), .perf_instret(perf_instret), .perf_memstall(perf_memstall),
`endif
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // kind: 0 retire, 1 trap, 2 memory timeout
  typedef struct {
    int kind; int cycles; int reqs; logic [18:0] sig; logic is_store; logic [3:0] be;
  } exp_t;

  exp_t exp_q[$];
  int   delay_q[$];
  int   tests = 0, fails = 0, events = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  function automatic logic [6:0] op_of(input int k);
    case (k)
      0: return 7'h37; 1: return 7'h17; 2: return 7'h6F; 3: return 7'h67;
      4: return 7'h63; 5: return 7'h13; 6: return 7'h33; 7: return 7'h03;
      8: return 7'h23; default: return 7'h00;
    endcase
  endfunction

  task automatic do_reset;
    rst = 1'b1;
    delay_q.delete();
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Reference model: derive the expected outcome from the instruction, then drive it
  task automatic issue(input int k, input logic [2:0] f3, input logic [6:0] f7, input logic br,
                       input logic [1:0] lsb, input int d1, input int d2, input bit no_resp,
                       output int kind_o);
    exp_t e; int ev0; bit legal, mis, ldst;
    logic [1:0] pm; logic a1, lrf, cm; logic [2:0] a2, aop, cop; logic [3:0] rfm;
    ldst  = (k == 7) || (k == 8);
    legal = (k <= 8);
    if (k == 4) legal = !(f3 == 2 || f3 == 3);
    if (k == 7) legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    if (k == 8) legal = (f3 <= 2);
    mis = ldst && ((f3[1:0] == 2 && lsb != 0) || (f3[1:0] == 1 && lsb[0]));
    pm = 0; a1 = 0; a2 = 0; aop = 0; cop = f3; rfm = 0; lrf = 1; cm = 0;
    case (k)
      0: rfm = 2;
      1: begin a1 = 1; a2 = 1; end
      2: begin pm = 1; a1 = 1; a2 = 4; rfm = 4; end
      3: begin pm = 2; rfm = 4; end
      4: begin pm = {1'b0, br}; a1 = 1; a2 = 2; lrf = 0; end
      5, 6: begin
        a2 = (k == 5) ? 3'd0 : 3'd5;
        if (f3 == 2 || f3 == 3) begin rfm = 1; cop = (f3 == 2) ? 3'd4 : 3'd6; cm = (k == 5); end
        else if (f3 == 5) aop = f7[5] ? 3'd2 : 3'd5;
        else if (f3 == 0 && k == 6 && f7[5]) aop = 3'd3;
        else aop = f3;
      end
      7: case (f3) 0: rfm = 5; 1: rfm = 7; 2: rfm = 3; 4: rfm = 6; default: rfm = 8; endcase
      8: lrf = 0;
      default: ;
    endcase
    e.sig = {1'b1, pm, a1, a2, rfm, lrf, aop, cop, cm};
    e.is_store = (k == 8);
    e.be = (f3[1:0] == 2) ? 4'hF : (f3[1:0] == 1) ? (4'h3 << lsb) : (4'h1 << lsb);
    e.reqs = 0;
    if (no_resp) begin e.kind = 2; e.cycles = MT + 2; e.reqs = MT; end
    else if (!legal) begin e.kind = 1; e.cycles = d1 + 5; end
    else if (mis) begin e.kind = 1; e.cycles = d1 + 6; end
    else begin e.kind = 0; e.cycles = ldst ? d1 + d2 + 7 : d1 + 5; end
    if (!no_resp) begin
      delay_q.push_back(d1);
      if (e.kind == 0 && ldst) delay_q.push_back(d2);
    end
    opcode = op_of(k); funct3 = f3; funct7 = f7; br_en = br; addr_lsb = lsb;
    exp_q.push_back(e);
    ev0 = events;
    for (int i = 0; i < 80 && events == ev0; i++) @(posedge clk);
    if (events == ev0) chk("event_timeout", 32'd0, 32'd1);
    #1;
    kind_o = e.kind;
  endtask

  // Memory responder: pulses mem_resp after the queued number of wait cycles
  initial begin
    int rcnt;
    rcnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin mem_resp = 1'b0; rcnt = 0; end
      else if (mem_resp) begin mem_resp = 1'b0; rcnt = 0; end
      else if ((mem_read || mem_write) && delay_q.size() > 0) begin
        if (rcnt >= delay_q[0]) begin mem_resp = 1'b1; void'(delay_q.pop_front()); end
        else rcnt++;
      end else rcnt = 0;
    end
  end

  // Monitor: pops the scoreboard on every retire or trap onset
  initial begin
    int cyc, reqc; logic trap_prev; logic [3:0] last_be; exp_t e; int got_kind;
    cyc = 0; reqc = 0; trap_prev = 1'b0; last_be = 4'hF;
    forever begin
      @(negedge clk);
      if (rst) begin cyc = 0; reqc = 0; trap_prev = 1'b0; end
      else begin
        cyc++;
        if (mem_read || mem_write) reqc++;
        if (mem_write) last_be = mem_byte_enable;
        if (retire || (trap && !trap_prev)) begin
          got_kind = retire ? 0 : (mem_err ? 2 : 1);
          if (exp_q.size() == 0) chk("unexpected_event", got_kind, 32'hFFFF_FFFF);
          else begin
            e = exp_q.pop_front();
            chk("outcome", got_kind, e.kind);
            chk("cycles", cyc, e.cycles);
            if (e.kind == 0)
              chk("retire_ctrl", {load_pc, pcmux_sel, alumux1_sel, alumux2_sel, regfilemux_sel,
                                  load_regfile, aluop, cmpop, cmpmux_sel}, e.sig);
            else chk("halt_no_req", {mem_read, mem_write, retire}, 3'b000);
            if (e.kind == 0 && e.is_store) chk("store_be", last_be, e.be);
            if (e.kind == 2) chk("timeout_req_cycles", reqc, e.reqs);
          end
          events++;
          cyc = 0; reqc = 0;
        end
        trap_prev = trap;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int kd, k, d1, d2; logic [2:0] f3; logic [6:0] f7; logic [1:0] lsb;
    do_reset;
    @(negedge clk);
    chk("reset_state", {trap, mem_read, mem_write, load_mar, mem_byte_enable, retire, mem_err, load_pc},
        10'b0_0_0_1_1111_0_0_0);
    do_reset;
    issue(5, 3'd0, 7'h00, 1'b0, 2'b00, 2, 0, 1'b0, kd);        // ADDI, 7 cycles
    issue(8, 3'd0, 7'h00, 1'b0, 2'b10, 1, 1, 1'b0, kd);        // SB lane 2
    issue(8, 3'd1, 7'h00, 1'b0, 2'b10, 0, 2, 1'b0, kd);        // SH upper half
    issue(8, 3'd2, 7'h00, 1'b0, 2'b00, 3, 0, 1'b0, kd);        // SW aligned
    issue(4, 3'd0, 7'h00, 1'b1, 2'b00, 1, 0, 1'b0, kd);        // BEQ taken
    issue(4, 3'd0, 7'h00, 1'b0, 2'b00, 0, 0, 1'b0, kd);        // BEQ not taken
    repeat (70) begin
      k  = $urandom_range(0, 9);
      f3 = 3'($urandom_range(0, 7));
      f7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      lsb = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2) lsb = 2'b00;
        else if (f3[1:0] == 1) lsb[0] = 1'b0;
      end
      d1 = $urandom_range(0, MT - 1);
      d2 = $urandom_range(0, MT - 1);
      issue(k, f3, f7, 1'($urandom_range(0, 1)), lsb, d1, d2, 1'b0, kd);
      if (kd != 0) do_reset;
    end
    issue(7, 3'd2, 7'h00, 1'b0, 2'b01, 1, 0, 1'b0, kd);        // misaligned LW
    repeat (20) begin
      @(negedge clk);
      chk("halt_hold", {trap, mem_read, mem_write}, 3'b100);
    end
    do_reset;
    @(negedge clk);
    chk("reset_exit", {trap, load_mar}, 2'b01);
    do_reset;
    issue(5, 3'd0, 7'h00, 1'b0, 2'b00, 0, 0, 1'b1, kd);        // fetch timeout
    @(negedge clk);
    chk("mem_err_pulse", {mem_err, trap, mem_read}, 3'b010);
    do_reset;
    issue(9, 3'd0, 7'h00, 1'b0, 2'b00, 1, 0, 1'b0, kd);        // illegal opcode 0
    repeat (10) @(negedge clk);
    chk("illegal_trap_held", trap, 1'b1);
`ifdef MC_CONTROL_PERF_EN
    chk("perf_cycle_frozen", perf_cycle, 32'd5);
    chk("perf_instret", perf_instret, 32'd0);
    chk("perf_memstall", perf_memstall, 32'd1);
`endif
    do_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mc_control_v2.md
Name: mc_control_v2

Overview:
- Parametrised multicycle RV32I control FSM. Sits between the instruction decode fields and the datapath mux/load controls, and drives the single unified memory port.
- Additions over the first-generation controller:
  - store path corrected (CALC_ADDR -> ST1 -> ST2);
  - misaligned load/store detection with trap;
  - memory-response watchdog;
  - registered byte-lane select;
  - sticky halt on fault;
  - single-cycle retire pulse.

Parameters:
- MEM_TIMEOUT, 255: max cycles waiting for mem_resp in FETCH2/LD1/ST1; 0 disables the watchdog.
- TRAP_ON_MISALIGN, 1: 1 = misaligned LW/LH/LHU/SW/SH traps; 0 = access proceeds with the same byte-enable masks as aligned.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- mem_resp  in  1  memory completion, single-cycle pulse
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]
- br_en  in  1  comparator result
- addr_lsb  in  2  ALU result [1:0], sampled in CALC_ADDR
- mem_read  out  1  read request
- mem_write  out  1  write request
- mem_byte_enable  out  4  write lane mask
- load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out  out  1 each  register load strobes
- pcmux_sel  out  2  0 pc+4, 1 alu_out, 2 alu_out&~1
- alumux1_sel  out  1  0 rs1, 1 pc
- alumux2_sel  out  3  0 i_imm, 1 u_imm, 2 b_imm, 3 s_imm, 4 j_imm, 5 rs2
- regfilemux_sel  out  4  0 alu, 1 br_en, 2 u_imm, 3 lw, 4 pc+4, 5 lb, 6 lbu, 7 lh, 8 lhu
- marmux_sel  out  1  0 pc, 1 alu_out
- cmpmux_sel  out  1  0 rs2, 1 i_imm
- aluop  out  3  0 add, 1 sll, 2 sra, 3 sub, 4 xor, 5 srl, 6 or, 7 and
- cmpop  out  3  branch funct3 encoding
- retire  out  1  one-cycle pulse when an instruction completes
- trap  out  1  sticky fault/halt indicator
- mem_err  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. Reset forces state FETCH1, byte_sel_q=0, wait_cnt=0, trap=0.
- Output defaults in every state:
  - all load strobes 0, mem_read=0, mem_write=0, mem_byte_enable=4'b1111;
  - all mux selects 0, aluop=add, cmpop=funct3;
  - retire=0, mem_err=0.
- States: FETCH1, FETCH2, FETCH3, DECODE, EXEC, CALC_ADDR, LD1, LD2, ST1, ST2, HALT.
- FETCH1: load_mar with marmux=pc; next FETCH2.
- FETCH2: mem_read=1, load_mdr=1, held until mem_resp; mem_resp -> FETCH3.
- FETCH3: load_ir; next DECODE.
- DECODE: legality check.
  - Legal opcodes: lui, auipc, jal, jalr, br, load, store, imm, reg.
  - Illegal funct3 for br, load or store counts as illegal.
  - Illegal -> HALT. Load/store -> CALC_ADDR. All others -> EXEC.
- EXEC: one cycle; load_pc, retire=1; next FETCH1.
  - lui: regfile=u_imm.
  - auipc: pc + u_imm.
  - jal: pc + j_imm -> pcmux 1; regfile=pc+4.
  - jalr: rs1 + i_imm -> pcmux 2; regfile=pc+4.
  - br: pc + b_imm; pcmux_sel={1'b0,br_en}; cmpmux=rs2.
  - imm/reg: slt/sltu use cmpop blt/bltu with regfile=br_en; sr uses funct7[5] ? sra : srl; reg add uses funct7[5] ? sub : add; otherwise aluop=funct3.
- CALC_ADDR: rs1 + (load ? i_imm : s_imm), marmux=1, load_mar; byte_sel_q <= addr_lsb; store also asserts load_data_out.
  - Misaligned means: word with lsb!=0, or half with lsb[0]=1.
  - If misaligned and TRAP_ON_MISALIGN=1 -> HALT; else load -> LD1, store -> ST1.
- LD1: mem_read, load_mdr until mem_resp -> LD2.
- LD2: regfile sel by funct3; load_pc pc+4; retire; next FETCH1.
- ST1: mem_write; mem_byte_enable sw 1111, sh 0011<<{byte_sel_q[1],0}, sb 0001<<byte_sel_q; held until mem_resp -> ST2.
- ST2: load_pc pc+4; retire; next FETCH1.
- Watchdog (MEM_TIMEOUT>0):
  - wait_cnt clears on entry to FETCH2/LD1/ST1 and increments each cycle mem_resp=0.
  - When wait_cnt==MEM_TIMEOUT-1 with no resp: drop the request the next cycle, pulse mem_err, enter HALT.
  - mem_resp on the expiry cycle wins (normal completion).
- HALT: all outputs at defaults except trap=1; no memory requests; exited only by rst.
- Reset mid-operation: requests deassert the cycle after rst is sampled; a pending mem_resp after reset is ignored in FETCH1.

Optional Feature:
- MC_CONTROL_PERF_EN defined: adds outputs perf_cycle[31:0], perf_instret[31:0], perf_memstall[31:0], all reset to 0 and wrapping modulo 2^32.
  - perf_cycle: increments every cycle not in HALT.
  - perf_instret: increments on retire.
  - perf_memstall: increments each cycle in FETCH2/LD1/ST1 with mem_resp=0.
- Undefined: these ports and their counters do not exist.

Test Plan:
- ADDI x1,x0,5 with mem_resp after 2 cycles -> FETCH1..DECODE, EXEC shows aluop=0, alumux2_sel=0, load_regfile=1, retire=1; 7 cycles total.
- SB with addr_lsb=2'b10 -> ST1 mem_byte_enable=4'b0100; SH with addr_lsb=2'b10 -> 4'b1100; SW aligned -> 4'b1111; each ends via ST2 with load_pc=1.
- LW with addr_lsb=2'b01, TRAP_ON_MISALIGN=1 -> no LD1; trap=1 held, mem_read=0 for 20 cycles; rst returns to FETCH1 with trap=0.
- MEM_TIMEOUT=4, mem_resp never asserted in FETCH2 -> mem_read high 4 cycles, then mem_err single pulse, trap=1.
- BEQ with br_en=1 then br_en=0 -> pcmux_sel=1 then 0, alumux1_sel=1, alumux2_sel=2, retire both.
- Opcode 7'b0000000 -> DECODE goes to HALT, trap=1; with MC_CONTROL_PERF_EN, perf_instret unchanged and perf_cycle frozen.
